// File: rtl/ddr3_frame_reader.sv
// Reads a stored MJPEG frame back from DDR3 in 128-bit beats and hands it to the udp128 packer
// one UDP packet at a time. Define RD_TIMEOUT_EN to add a watchdog with a sticky o_err_timeout.
module ddr3_frame_reader #(
    parameter int unsigned PKT_BEATS      = 64,
    parameter int unsigned ADDR_STEP      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_frame_valid,
    input  logic [27:0]  i_frame_base_addr,
    input  logic [15:0]  i_frame_len,
    output logic         o_ready,
    output logic         o_frame_done,
    output logic [2:0]   o_ddr3_cmd,
    output logic         o_ddr3_cmd_en,
    output logic [27:0]  o_ddr3_addr,
    input  logic         i_ddr3_cmd_ready,
    input  logic [127:0] i_ddr3_rd_data,
    input  logic         i_ddr3_rd_data_de,
    output logic         o_udp128_en,
    output logic [127:0] o_udp128_ddr3_udp_wrdata,
    output logic         o_udp128_udp_last_frame_flag,
    output logic [14:0]  o_udp128_mjpeg_frame_rank,
    output logic [15:0]  o_udp128_udp_jpeg_len,
    output logic [15:0]  o_udp128_udp_ipv4_sign,
    input  logic         i_udp128_ddr3_data_upd_req,
    input  logic         i_udp128_udp_frame_down,
    input  logic         i_udp128_busy
`ifdef RD_TIMEOUT_EN
    ,
    output logic         o_err_timeout
`endif
);

    typedef enum logic [2:0] {StIdle, StWaitReq, StIssue, StDrain, StWaitDown} state_e;

    state_e      state;
    logic [12:0] rem_beats;
    logic [8:0]  pkt_beats;
    logic [8:0]  issued;
    logic [8:0]  received;
    logic        down_pending;
    logic        tmo_hit;
    logic [12:0] desc_beats;
    logic        fits;
    logic        rd_active;
    logic        down_seen;

    assign desc_beats = 13'((32'(i_frame_len) + 32'd15) >> 4);
    assign fits       = rem_beats <= 13'(PKT_BEATS);
    assign rd_active  = (state == StIssue) || (state == StDrain);
    assign down_seen  = down_pending || i_udp128_udp_frame_down;
    assign o_ready    = (state == StIdle);
    assign o_ddr3_cmd = o_ddr3_cmd_en ? 3'b001 : 3'b000;

`ifdef RD_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_cnt;
    state_e          state_prev;
    logic            err_timeout;

    // state_prev lags by one cycle, so a fresh state never inherits a stale count
    assign tmo_hit = (state == state_prev) &&
                     ((state == StIssue) || (state == StDrain) || (state == StWaitDown)) &&
                     (tmo_cnt >= TmoW'(TIMEOUT_CYCLES));
    assign o_err_timeout = err_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt     <= '0;
            state_prev  <= StIdle;
            err_timeout <= 1'b0;
        end else begin
            state_prev <= state;
            if ((state != state_prev) || i_ddr3_rd_data_de) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt < TmoW'(TIMEOUT_CYCLES)) begin
                tmo_cnt <= tmo_cnt + TmoW'(1);
            end
            if (tmo_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                        <= StIdle;
            rem_beats                    <= '0;
            pkt_beats                    <= '0;
            issued                       <= '0;
            received                     <= '0;
            down_pending                 <= 1'b0;
            o_frame_done                 <= 1'b0;
            o_ddr3_cmd_en                <= 1'b0;
            o_ddr3_addr                  <= '0;
            o_udp128_en                  <= 1'b0;
            o_udp128_ddr3_udp_wrdata     <= '0;
            o_udp128_udp_last_frame_flag <= 1'b0;
            o_udp128_mjpeg_frame_rank    <= '0;
            o_udp128_udp_jpeg_len        <= '0;
            o_udp128_udp_ipv4_sign       <= '0;
        end else begin
            o_frame_done <= 1'b0;
            o_udp128_en  <= i_ddr3_rd_data_de && rd_active;
            if (i_ddr3_rd_data_de && rd_active) begin
                o_udp128_ddr3_udp_wrdata <= i_ddr3_rd_data;
                received                 <= received + 9'd1;
            end
            // an early frame_down is held until WAIT_DOWN consumes it
            if (rd_active && i_udp128_udp_frame_down) begin
                down_pending <= 1'b1;
            end

            if (tmo_hit) begin
                state         <= StIdle;
                o_ddr3_cmd_en <= 1'b0;
                down_pending  <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        if (i_frame_valid) begin
                            if (i_frame_len != 16'd0) begin
                                o_ddr3_addr               <= i_frame_base_addr;
                                o_udp128_udp_jpeg_len     <= i_frame_len;
                                o_udp128_mjpeg_frame_rank <= '0;
                                rem_beats                 <= desc_beats;
                                state                     <= StWaitReq;
                            end else begin
                                o_frame_done <= 1'b1;
                            end
                        end
                    end
                    StWaitReq: begin
                        if (i_udp128_ddr3_data_upd_req && !i_udp128_busy) begin
                            o_udp128_udp_last_frame_flag <= fits;
                            pkt_beats     <= fits ? rem_beats[8:0] : 9'(PKT_BEATS);
                            issued        <= '0;
                            received      <= '0;
                            down_pending  <= 1'b0;
                            o_ddr3_cmd_en <= 1'b1;
                            state         <= StIssue;
                        end
                    end
                    StIssue: begin
                        if (i_ddr3_cmd_ready) begin
                            o_ddr3_addr <= o_ddr3_addr + 28'(ADDR_STEP);
                            issued      <= issued + 9'd1;
                            if (issued + 9'd1 == pkt_beats) begin
                                o_ddr3_cmd_en <= 1'b0;
                                state         <= StDrain;
                            end
                        end
                    end
                    StDrain: begin
                        if (received == pkt_beats) begin
                            state <= StWaitDown;
                        end
                    end
                    StWaitDown: begin
                        if (down_seen) begin
                            o_udp128_udp_ipv4_sign <= o_udp128_udp_ipv4_sign + 16'd1;
                            rem_beats              <= rem_beats - 13'(pkt_beats);
                            down_pending           <= 1'b0;
                            if (o_udp128_udp_last_frame_flag) begin
                                o_frame_done <= 1'b1;
                                state        <= StIdle;
                            end else begin
                                o_udp128_mjpeg_frame_rank <= o_udp128_mjpeg_frame_rank + 15'd1;
                                state                     <= StWaitReq;
                            end
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: doc/ddr3_frame_reader.md
Name: ddr3_frame_reader

Overview:
- Read-side counterpart of the DDR3 MJPEG frame writer.
- Takes a stored-frame descriptor (base address, JPEG byte length) and reads the frame back from DDR3 in 128-bit beats.
- Slices the frame into UDP payload packets and delivers beats to the udp128 packer on its request/done handshake.
- Sits between the DDR3 controller user port (read commands only) and the udp128 packer.

Parameters:
- PKT_BEATS, 64, 128-bit beats per UDP packet (1024 payload bytes); legal range 1..256.
- ADDR_STEP, 8, DDR3 address increment per read command (one 128-bit beat per command).
- TIMEOUT_CYCLES, 4096, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  DDR3 user clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_frame_valid  in  1  descriptor strobe; sampled only in IDLE.
- i_frame_base_addr  in  28  {rank,bank,row,col} start address of the frame.
- i_frame_len  in  16  JPEG length in bytes.
- o_ready  out  1  high in IDLE only.
- o_frame_done  out  1  one-cycle pulse after the last packet's done.
- o_ddr3_cmd  out  3  3'b001 = read; 3'b000 otherwise.
- o_ddr3_cmd_en  out  1  command strobe.
- o_ddr3_addr  out  28  command address.
- i_ddr3_cmd_ready  in  1  controller accepts a command this cycle.
- i_ddr3_rd_data  in  128  read data.
- i_ddr3_rd_data_de  in  1  read data valid.
- o_udp128_en  out  1  beat valid to packer.
- o_udp128_ddr3_udp_wrdata  out  128  beat data.
- o_udp128_udp_last_frame_flag  out  1  current packet is the last of the frame.
- o_udp128_mjpeg_frame_rank  out  15  packet index within the frame, starting at 0.
- o_udp128_udp_jpeg_len  out  16  latched i_frame_len.
- o_udp128_udp_ipv4_sign  out  16  IPv4 identification; +1 per packet, free-running.
- i_udp128_ddr3_data_upd_req  in  1  packer requests the next packet's data.
- i_udp128_udp_frame_down  in  1  packer finished sending the current packet.
- i_udp128_busy  in  1  packer busy; blocks the start of a new packet.
- o_err_timeout  out  1  sticky watchdog flag; present only with RD_TIMEOUT_EN.

Behaviour:
- Reset: all outputs are 0, except o_ready, which is 1. State is IDLE, and all counters are 0, including ipv4_sign.
- IDLE:
  - i_frame_valid with i_frame_len != 0: latch the base address and length, set rank=0, rem_beats=ceil(len/16) (17-bit intermediate), then go to WAIT_REQ.
  - i_frame_valid with len=0: ignored; o_frame_done pulses the next cycle.
- WAIT_REQ:
  - Leave only on i_udp128_ddr3_data_upd_req=1 with i_udp128_busy=0.
  - pkt_beats = min(PKT_BEATS, rem_beats).
  - last_frame_flag = (rem_beats <= PKT_BEATS); it is registered and stable for the whole packet.
  - Go to ISSUE.
- ISSUE:
  - o_ddr3_cmd_en=1 with cmd 3'b001 and the current address, held until i_ddr3_cmd_ready.
  - Each accepted command: addr += ADDR_STEP (28-bit wrap) and issued += 1.
  - After pkt_beats commands have been accepted, go to DRAIN. No more than pkt_beats commands are ever issued.
- Read return, in ISSUE or DRAIN:
  - Each i_ddr3_rd_data_de produces o_udp128_en=1 with the data on the next cycle (1-cycle latency, no FIFO).
  - The received count increments on each beat.
  - rd_data_de outside ISSUE/DRAIN is dropped.
- DRAIN: when received == pkt_beats, go to WAIT_DOWN.
- WAIT_DOWN, on i_udp128_udp_frame_down:
  - ipv4_sign += 1.
  - rem_beats -= pkt_beats.
  - If last: o_frame_done pulse, then IDLE.
  - Else: rank += 1, then WAIT_REQ.
- Simultaneous events:
  - frame_down arriving early (in ISSUE/DRAIN) is latched and consumed on entry to WAIT_DOWN.
  - upd_req while not in WAIT_REQ is ignored.
- Frame-level output stability: jpeg_len and rank stay stable from WAIT_REQ exit until the frame_down that ends the packet.
- Trailing bytes: partial-beat bytes of the last beat are passed unmasked; the packer trims them using jpeg_len.
- Reset mid-operation: immediate return to the reset state. Outstanding controller read data arriving after reset is dropped.

Optional Feature:
- Macro RD_TIMEOUT_EN.
- When defined:
  - A counter clears on every state change and on every rd_data_de.
  - If it reaches TIMEOUT_CYCLES in ISSUE, DRAIN or WAIT_DOWN: o_err_timeout is set (sticky until reset), the FSM goes to IDLE, and no o_frame_done is generated.
- When undefined: no counter, o_err_timeout port absent, and the FSM waits indefinitely.

Test Plan:
- len=1024, base=0: one upd_req, data returned with random gaps -> 64 read commands at addr 0,8,…,504; 64 o_udp128_en beats; last_flag=1; rank=0; after frame_down, o_frame_done pulses and ipv4_sign=1.
- len=2500: packets of 64, 64 and 29 beats -> ranks 0,1,2; last_flag only on rank 2; ipv4_sign increments by 3; final command address = base+156*8.
- i_ddr3_cmd_ready low 10 cycles mid-packet -> cmd_en and addr held; no command skipped or duplicated.
- i_udp128_busy=1 while upd_req=1 -> stays in WAIT_REQ with no commands issued; busy drop -> ISSUE next cycle.
- len=0 descriptor -> no commands, o_frame_done one-cycle pulse. Also: rst_n asserted mid-ISSUE -> all outputs at reset values, o_ready=1.
- RD_TIMEOUT_EN with TIMEOUT_CYCLES=16: suppress rd_data_de -> o_err_timeout=1 after 16 cycles, FSM in IDLE, no o_frame_done.
